// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared definitions for the button gesture classifier:
//   - gesture_state_e : FSM state encoding used by button_gesture_ctrl
//   - EVT_* constants  : 2-bit gesture codes presented on evt_code
//   - max_u()          : helper used to size the shared press/gap counter
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT_GAP  = 3'd3,
    SECOND    = 3'd4
  } gesture_state_e;

  // Gesture codes. 2'b00 is reserved as "no gesture" and never leaves the
  // event register while valid is high.
  localparam logic [1:0] EVT_NONE   = 2'b00;
  localparam logic [1:0] EVT_SHORT  = 2'b01;
  localparam logic [1:0] EVT_LONG   = 2'b10;
  localparam logic [1:0] EVT_DOUBLE = 2'b11;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gesture_evt_reg.sv
// ---------------------------------------------------------------------------
// gesture_evt_reg
// One-entry holding register for classified gestures with a valid/ready
// handshake towards the consumer and a sticky overflow flag.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset (clears entry and overflow)
//   load_i     : one-cycle request to store a newly generated gesture
//   code_i     : gesture code accompanying load_i
//   ready_i    : consumer accepts the pending gesture this cycle
//   valid_o    : a gesture is pending
//   code_o     : pending gesture code (EVT_NONE while empty)
//   overflow_o : sticky, set when a gesture had to be dropped
//
// The producer never waits: a load that arrives while the entry is full and
// not being drained is discarded, the old entry is kept and overflow is set.
// A load coinciding with an accept replaces the entry with no overflow.
// ---------------------------------------------------------------------------
module gesture_evt_reg
  import button_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic [1:0] code_i,
  input  logic       ready_i,
  output logic       valid_o,
  output logic [1:0] code_o,
  output logic       overflow_o
);

  logic       valid_q, valid_d;
  logic [1:0] code_q, code_d;
  logic       overflow_q, overflow_d;
  logic       accept;
  logic       has_room;

  assign accept   = valid_q & ready_i;
  // The slot is usable if it is empty or being emptied in this very cycle.
  assign has_room = ~valid_q | accept;

  always_comb begin
    valid_d    = valid_q;
    code_d     = code_q;
    overflow_d = overflow_q;
    if (load_i) begin
      if (has_room) begin
        valid_d = 1'b1;
        code_d  = code_i;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
      code_d  = EVT_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      code_q     <= EVT_NONE;
      overflow_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      code_q     <= code_d;
      overflow_q <= overflow_d;
    end
  end

  assign valid_o    = valid_q;
  assign code_o     = code_q;
  assign overflow_o = overflow_q;

endmodule

// File: rtl/button_gesture_ctrl.sv
// ---------------------------------------------------------------------------
// button_gesture_ctrl
// Classifies debounced button activity into short press, long press and
// double click gestures and hands them to a consumer through a one-entry
// valid/ready register.
//
// Parameters:
//   LONG_CYCLES : press duration (clk cycles) that makes a press "long" (>=2)
//   GAP_CYCLES  : longest release gap (clk cycles) for a double click  (>=2)
//
// Ports:
//   clk       : system clock, rising edge
//   rst       : synchronous active-high reset, aborts any gesture in flight
//   p_edge    : one-cycle pulse, debounced press start
//   n_edge    : one-cycle pulse, debounced release
//   evt_valid : a classified gesture is pending
//   evt_code  : 01 short, 10 long, 11 double
//   evt_ready : consumer accepts the pending gesture
//   busy      : FSM is in the middle of a gesture (not IDLE)
//   overflow  : sticky, a gesture was dropped because the consumer stalled
//
// A single counter is shared: it times the press in PRESSED/SECOND and the
// release gap in WAIT_GAP, and is cleared on every state entry that starts
// a new timing interval.
// ---------------------------------------------------------------------------
module button_gesture_ctrl
  import button_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 50_000_000,
  parameter int unsigned GAP_CYCLES  = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p_edge,
  input  logic       n_edge,
  output logic       evt_valid,
  output logic [1:0] evt_code,
  input  logic       evt_ready,
  output logic       busy,
  output logic       overflow
);

  localparam int unsigned CNT_W = $clog2(max_u(LONG_CYCLES, GAP_CYCLES));
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

  gesture_state_e   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A cycle carrying both edges is contradictory and treated as quiet.
  logic press;
  logic release_ev;
  assign press      = p_edge & ~n_edge;
  assign release_ev = n_edge & ~p_edge;

  logic       evt_gen;
  logic [1:0] evt_gen_code;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and counter logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (press) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end
      end

      PRESSED, SECOND: begin
        if (cnt_q == LONG_LAST) begin
          // Long threshold reached. A release landing on this exact cycle
          // still counts as long; the button is already up, so skip
          // LONG_HELD and go straight back to IDLE.
          if (release_ev) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = LONG_HELD;
          end
        end else if (release_ev) begin
          state_d = (state_q == PRESSED) ? WAIT_GAP : IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      LONG_HELD: begin
        // Counter parks at LONG_LAST until the button is released.
        if (release_ev) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      WAIT_GAP: begin
        // A second press wins over gap expiry in the same cycle.
        if (press) begin
          state_d = SECOND;
          cnt_d   = '0;
        end else if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Output logic: busy flag and gesture generation (Mealy, one cycle pulse)
  // -------------------------------------------------------------------------
  always_comb begin
    busy         = (state_q != IDLE);
    evt_gen      = 1'b0;
    evt_gen_code = EVT_SHORT;
    unique case (state_q)
      PRESSED: begin
        if (cnt_q == LONG_LAST) begin
          evt_gen      = 1'b1;
          evt_gen_code = EVT_LONG;
        end
      end

      SECOND: begin
        // A second press that turns long reports long only; the pending
        // first click is absorbed into it.
        if (cnt_q == LONG_LAST) begin
          evt_gen      = 1'b1;
          evt_gen_code = EVT_LONG;
        end else if (release_ev) begin
          evt_gen      = 1'b1;
          evt_gen_code = EVT_DOUBLE;
        end
      end

      WAIT_GAP: begin
        if (!press && (cnt_q == GAP_LAST)) begin
          evt_gen      = 1'b1;
          evt_gen_code = EVT_SHORT;
        end
      end

      default: begin
        evt_gen      = 1'b0;
        evt_gen_code = EVT_SHORT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Event holding register (never back-pressures the FSM)
  // -------------------------------------------------------------------------
  gesture_evt_reg u_evt_reg (
    .clk        (clk),
    .rst        (rst),
    .load_i     (evt_gen),
    .code_i     (evt_gen_code),
    .ready_i    (evt_ready),
    .valid_o    (evt_valid),
    .code_o     (evt_code),
    .overflow_o (overflow)
  );

endmodule

// File: tb/tb_button_gesture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_gesture_ctrl
// Directed checks of button_gesture_ctrl with LONG_CYCLES=8, GAP_CYCLES=5.
// Cycle c is the window between rising edges; inputs driven in cycle c are
// sampled at the edge ending it, outputs are observed 1 time unit into c.
// ---------------------------------------------------------------------------
module tb_button_gesture_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p_edge = 1'b0;
  logic       n_edge = 1'b0;
  logic       evt_ready = 1'b1;
  logic       evt_valid;
  logic [1:0] evt_code;
  logic       busy;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  button_gesture_ctrl #(
    .LONG_CYCLES (8),
    .GAP_CYCLES  (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_edge    (p_edge),
    .n_edge    (n_edge),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ready (evt_ready),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int c, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, c, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    p_edge    = 1'b0;
    n_edge    = 1'b0;
    evt_ready = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    tick();
    check("rst_valid", 0, 2'(evt_valid), 2'b0);
    check("rst_code", 0, evt_code, 2'b00);
    check("rst_busy", 0, 2'(busy), 2'b0);
    check("rst_overflow", 0, 2'(overflow), 2'b0);
    rst = 1'b0;
    $display("txn reset: valid=%0b code=%0b busy=%0b ovf=%0b", evt_valid, evt_code, busy, overflow);

    // Short press: p@0 n@3 -> code 01 at cycle 9 only
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      p_edge = (c == 0);
      n_edge = (c == 3);
      check("short_valid", c, 2'(evt_valid), 2'(c == 9));
      if (c == 9) check("short_code", c, evt_code, 2'b01);
      if (c != 9) check("short_busy", c, 2'(busy), 2'(c >= 1 && c <= 8));
      tick();
    end
    $display("txn short press done");

    // Long press: p@0 n@20 -> code 10 at cycle 9, busy low from 21
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      p_edge = (c == 0);
      n_edge = (c == 20);
      check("long_valid", c, 2'(evt_valid), 2'(c == 9));
      if (c == 9) check("long_code", c, evt_code, 2'b10);
      check("long_busy", c, 2'(busy), 2'(c >= 1 && c <= 20));
      tick();
    end
    $display("txn long press done");

    // Double click: p@0 n@2 p@5 n@7 -> code 11 at cycle 8, nothing else
    do_reset();
    for (int c = 0; c <= 15; c++) begin
      p_edge = (c == 0 || c == 5);
      n_edge = (c == 2 || c == 7);
      check("double_valid", c, 2'(evt_valid), 2'(c == 8));
      if (c == 8) check("double_code", c, evt_code, 2'b11);
      tick();
    end
    $display("txn double click done");

    // Backpressure: two short presses, consumer stalled until cycle 22
    do_reset();
    for (int c = 0; c <= 24; c++) begin
      p_edge    = (c == 0 || c == 12);
      n_edge    = (c == 3 || c == 14);
      evt_ready = (c >= 22);
      check("bp_valid", c, 2'(evt_valid), 2'(c >= 9 && c <= 22));
      if (c >= 9 && c <= 22) check("bp_code", c, evt_code, 2'b01);
      check("bp_overflow", c, 2'(overflow), 2'(c >= 20));
      tick();
    end
    $display("txn backpressure done: ovf=%0b", overflow);

    // Accept and load in the same cycle: no overflow, new code replaces old
    do_reset();
    for (int c = 0; c <= 22; c++) begin
      p_edge    = (c == 0 || c == 12 || c == 17);
      n_edge    = (c == 3 || c == 14 || c == 19);
      evt_ready = (c == 19);
      check("acc_valid", c, 2'(evt_valid), 2'(c >= 9));
      if (c >= 9 && c < 20) check("acc_code_old", c, evt_code, 2'b01);
      if (c >= 20) check("acc_code_new", c, evt_code, 2'b11);
      check("acc_overflow", c, 2'(overflow), 2'b0);
      tick();
    end
    $display("txn accept+load done");

    // Reset mid-gesture; an edge in the reset cycle is ignored
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      rst    = (c == 4);
      p_edge = (c == 0 || c == 4);
      n_edge = (c == 6);
      check("rstmid_busy", c, 2'(busy), 2'(c >= 1 && c <= 4));
      check("rstmid_valid", c, 2'(evt_valid), 2'b0);
      tick();
    end
    rst = 1'b0;
    $display("txn reset mid-gesture done");

    // Reset discards a pending event and aborts LONG_HELD
    do_reset();
    for (int c = 0; c <= 16; c++) begin
      evt_ready = 1'b0;
      rst       = (c == 11);
      p_edge    = (c == 0);
      n_edge    = (c == 13);
      check("rstpend_valid", c, 2'(evt_valid), 2'(c >= 9 && c <= 11));
      if (c >= 9 && c <= 11) check("rstpend_code", c, evt_code, 2'b10);
      if (c >= 12) check("rstpend_code0", c, evt_code, 2'b00);
      check("rstpend_busy", c, 2'(busy), 2'(c >= 1 && c <= 11));
      tick();
    end
    rst = 1'b0;
    $display("txn reset with pending event done");

    // Simultaneous edges in IDLE are ignored
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      p_edge = (c == 0);
      n_edge = (c == 0);
      check("simul_idle_busy", c, 2'(busy), 2'b0);
      check("simul_idle_valid", c, 2'(evt_valid), 2'b0);
      tick();
    end
    $display("txn simultaneous edges in IDLE done");

    // Simultaneous edges mid-press: counter keeps running, release at 5
    do_reset();
    for (int c = 0; c <= 13; c++) begin
      p_edge = (c == 0 || c == 3);
      n_edge = (c == 3 || c == 5);
      check("simul_press_valid", c, 2'(evt_valid), 2'(c == 11));
      if (c == 11) check("simul_press_code", c, evt_code, 2'b01);
      tick();
    end
    $display("txn simultaneous edges mid-press done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
